// File: rtl/mdv_multi.sv
// Multi-drive microdrive replay engine: streams the selected drive's image from shared RAM
// with header/sector gap framing. Define MDV_REVERSE_EN to add descending-sector replay.
module mdv_multi #(
    parameter int DRIVES    = 2,
    parameter int AW        = 17,
    parameter int CLK_DIV   = 13,
    parameter int GAP_WORDS = 35,
    parameter int HDR_WORDS = 14,
    parameter int SEC_WORDS = 329,
    parameter int PRE_WORDS = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic [DRIVES-1:0] sel,
    output logic              gap,
    output logic              tx_empty,
    output logic              rx_ready,
    output logic [7:0]        dout,
    input  logic              download,
    input  logic [2:0]        dl_drive,
    input  logic [AW-1:0]     dl_addr,
    input  logic              dl_wr,
    output logic [AW+2:0]     mem_addr,
`ifdef MDV_REVERSE_EN
    input  logic              reverse,
`endif
    input  logic [15:0]       mem_q
);

    localparam int DVW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int MAXC_A = (GAP_WORDS > HDR_WORDS) ? GAP_WORDS : HDR_WORDS;
    localparam int MAXC   = (MAXC_A > SEC_WORDS) ? MAXC_A : SEC_WORDS;
    localparam int CW_RAW = $clog2(MAXC + 1);
    localparam int CW     = (CW_RAW > 4) ? CW_RAW : 4;

    localparam logic [DVW-1:0] DIV_LAST = DVW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  GAP_LAST = CW'(GAP_WORDS - 1);
    localparam logic [CW-1:0]  HDR_LAST = CW'(HDR_WORDS - 1);
    localparam logic [CW-1:0]  SEC_LAST = CW'(SEC_WORDS - 1);
    localparam logic [CW-1:0]  PRE_CNT  = CW'(PRE_WORDS);
    localparam logic [AW-1:0]  SPAN_M1  = AW'(HDR_WORDS + SEC_WORDS - 1);
    localparam logic [AW-1:0]  BACK_STEP = AW'(2 * (HDR_WORDS + SEC_WORDS) - 1);
    localparam logic [3:0]     DRIVES_L = 4'(DRIVES);

    typedef enum logic [1:0] {
        ST_GAP_HDR = 2'd0,
        ST_HDR     = 2'd1,
        ST_GAP_SEC = 2'd2,
        ST_SEC     = 2'd3
    } state_t;

    // End-address table is sized to the full 3-bit drive space; unused entries stay zero.
    logic [AW-1:0]  end_addr_r [8];
    logic [DVW-1:0] div_r, div_nxt_s;
    logic [3:0]     bit_cnt_r, bit_cnt_nxt_s;
    logic [15:0]    data_r, data_nxt_s;
    logic           data_valid_r, data_valid_nxt_s;
    logic [CW-1:0]  cnt_r, cnt_nxt_s;
    logic [AW-1:0]  addr_r, addr_nxt_s;
    state_t         state_r, state_nxt_s;
    logic [2:0]     prev_active_r;
    logic           prev_sel_nz_r;
    logic           gap_r;
    logic           rx_ready_r;
    logic [7:0]     dout_r;
    logic [AW+2:0]  mem_addr_r;

    logic [2:0]     active_s;
    logic           sel_nz_s;
    logic [AW-1:0]  end_cur_s;
    logic           present_s;
    logic           tick_s;
    logic           word_tick_s;
    logic           restart_s;
    logic           wrap_s;
    logic           in_data_s;
    logic           sec_mask_s;
    logic           reverse_s;

`ifdef MDV_REVERSE_EN
    assign reverse_s = reverse;
`else
    assign reverse_s = 1'b0;
`endif

    assign sel_nz_s    = (sel != '0);
    assign end_cur_s   = end_addr_r[active_s];
    assign present_s   = sel_nz_s && (end_cur_s != '0);
    assign tick_s      = ce && (div_r == '0);
    assign word_tick_s = tick_s && (bit_cnt_r == 4'd15);
    assign restart_s   = (download && (dl_drive == active_s))
                       || (active_s != prev_active_r)
                       || (sel_nz_s && !prev_sel_nz_r);
    assign wrap_s      = word_tick_s && (addr_r > end_cur_s);
    assign in_data_s   = (state_r == ST_HDR) || (state_r == ST_SEC);
    assign sec_mask_s  = (state_r == ST_SEC) && (cnt_r >= CW'(8)) && (cnt_r <= CW'(11));

    assign gap      = gap_r;
    assign tx_empty = 1'b0;
    assign rx_ready = rx_ready_r;
    assign dout     = dout_r;
    assign mem_addr = mem_addr_r;

    // Priority select: lowest set bit of sel wins (scan downward so low bits overwrite).
    always_comb begin
        active_s = 3'd0;
        for (int i = DRIVES - 1; i >= 0; i--) begin
            active_s = sel[i] ? 3'(i) : active_s;
        end
    end

    // Upload captures the last written word address as the image end for that drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                end_addr_r[i] <= '0;
            end
        end else if (dl_wr && ({1'b0, dl_drive} < DRIVES_L)) begin
            end_addr_r[dl_drive] <= dl_addr;
        end
    end

    // Bit/word timing, data capture and framing FSM next-state.
    always_comb begin
        div_nxt_s        = div_r;
        bit_cnt_nxt_s    = bit_cnt_r;
        data_nxt_s       = data_r;
        data_valid_nxt_s = data_valid_r;
        cnt_nxt_s        = cnt_r;
        addr_nxt_s       = addr_r;
        state_nxt_s      = state_r;

        if (ce) begin
            div_nxt_s = (div_r == DIV_LAST) ? '0 : div_r + DVW'(1);
        end else begin
            div_nxt_s = div_r;
        end

        if (tick_s) begin
            bit_cnt_nxt_s = bit_cnt_r + 4'd1;
        end else begin
            bit_cnt_nxt_s = bit_cnt_r;
        end

        if (word_tick_s) begin
            data_nxt_s       = mem_q;
            data_valid_nxt_s = in_data_s && (cnt_r >= PRE_CNT) && !sec_mask_s;
            cnt_nxt_s        = cnt_r + CW'(1);
        end else begin
            data_nxt_s = data_r;
        end

        // Restart (select change, upload hold) outranks wrap, which outranks the FSM.
        if (restart_s || wrap_s) begin
            addr_nxt_s       = '0;
            state_nxt_s      = ST_GAP_HDR;
            cnt_nxt_s        = '0;
            data_valid_nxt_s = 1'b0;
        end else if (word_tick_s) begin
            case (state_r)
                ST_GAP_HDR: begin
                    if (cnt_r == GAP_LAST) begin
                        state_nxt_s = ST_HDR;
                        cnt_nxt_s   = '0;
                    end else begin
                        state_nxt_s = ST_GAP_HDR;
                    end
                end
                ST_HDR: begin
                    addr_nxt_s = addr_r + AW'(1);
                    if (cnt_r == HDR_LAST) begin
                        state_nxt_s = ST_GAP_SEC;
                        cnt_nxt_s   = '0;
                    end else begin
                        state_nxt_s = ST_HDR;
                    end
                end
                ST_GAP_SEC: begin
                    if (cnt_r == GAP_LAST) begin
                        state_nxt_s = ST_SEC;
                        cnt_nxt_s   = '0;
                    end else begin
                        state_nxt_s = ST_GAP_SEC;
                    end
                end
                ST_SEC: begin
                    if (cnt_r == SEC_LAST) begin
                        state_nxt_s = ST_GAP_HDR;
                        cnt_nxt_s   = '0;
                        if (!reverse_s) begin
                            addr_nxt_s = addr_r + AW'(1);
                        end else if (addr_r == SPAN_M1) begin
                            addr_nxt_s = end_cur_s - SPAN_M1;
                        end else begin
                            addr_nxt_s = addr_r - BACK_STEP;
                        end
                    end else begin
                        state_nxt_s = ST_SEC;
                        addr_nxt_s  = addr_r + AW'(1);
                    end
                end
                default: begin
                    state_nxt_s = ST_GAP_HDR;
                    cnt_nxt_s   = '0;
                    addr_nxt_s  = '0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State register; outputs are registered from the next-state values.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r         <= '0;
            bit_cnt_r     <= 4'd0;
            data_r        <= 16'd0;
            data_valid_r  <= 1'b0;
            cnt_r         <= '0;
            addr_r        <= '0;
            state_r       <= ST_GAP_HDR;
            prev_active_r <= 3'd0;
            prev_sel_nz_r <= 1'b0;
            gap_r         <= 1'b1;
            rx_ready_r    <= 1'b0;
            dout_r        <= 8'd0;
            mem_addr_r    <= '0;
        end else begin
            div_r         <= div_nxt_s;
            bit_cnt_r     <= bit_cnt_nxt_s;
            data_r        <= data_nxt_s;
            data_valid_r  <= data_valid_nxt_s;
            cnt_r         <= cnt_nxt_s;
            addr_r        <= addr_nxt_s;
            state_r       <= state_nxt_s;
            prev_active_r <= active_s;
            prev_sel_nz_r <= sel_nz_s;
            gap_r         <= !present_s || (state_nxt_s == ST_GAP_HDR) || (state_nxt_s == ST_GAP_SEC);
            rx_ready_r    <= present_s && data_valid_nxt_s && (bit_cnt_nxt_s[2:0] == 3'd2);
            dout_r        <= bit_cnt_nxt_s[3] ? data_nxt_s[7:0] : data_nxt_s[15:8];
            mem_addr_r    <= {active_s, addr_nxt_s};
        end
    end

endmodule

// File: tb/tb_mdv_multi.sv
// Scoreboard bench for mdv_multi with shrunk framing so whole image passes fit in a short run.
module tb_mdv_multi;

    localparam int AW   = 10;
    localparam int DRV  = 2;
    localparam int HDRW = 3;
    localparam int SECW = 14;
    localparam int PREW = 1;
    localparam int GAPW = 4;
    localparam int S    = HDRW + SECW;
    localparam int WCLK = 64;

    logic           clk, reset, ce, download, dl_wr;
    logic           gap, tx_empty, rx_ready;
    logic [DRV-1:0] sel;
    logic [7:0]     dout;
    logic [2:0]     dl_drive;
    logic [AW-1:0]  dl_addr;
    logic [AW+2:0]  mem_addr;
    logic [15:0]    mem_q;
`ifdef MDV_REVERSE_EN
    logic           reverse;
`endif

    logic [15:0] mem [0:(1 << (AW + 3)) - 1];
    logic [7:0]  exp_q [$];
    logic [2:0]  exp_drive;
    logic        rx_prev;
    int          checks;
    int          errors;

    mdv_multi #(
        .DRIVES(DRV), .AW(AW), .CLK_DIV(2), .GAP_WORDS(GAPW),
        .HDR_WORDS(HDRW), .SEC_WORDS(SECW), .PRE_WORDS(PREW)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .sel(sel), .gap(gap),
        .tx_empty(tx_empty), .rx_ready(rx_ready), .dout(dout),
        .download(download), .dl_drive(dl_drive), .dl_addr(dl_addr),
        .dl_wr(dl_wr), .mem_addr(mem_addr),
`ifdef MDV_REVERSE_EN
        .reverse(reverse),
`endif
        .mem_q(mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        ce = 1'b0;
        forever begin
            @(negedge clk);
            ce = ~ce;
        end
    end

    always @(posedge clk) mem_q <= mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Each new byte (rising rx_ready) is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (rx_ready === 1'b1 && rx_prev !== 1'b1) begin
            chk("byte_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk("dout", 32'(dout), 32'(exp_q.pop_front()));
                chk("byte_drive", 32'(mem_addr[AW+2:AW]), 32'(exp_drive));
            end
        end
        rx_prev = rx_ready;
    end

    task automatic push_word(input logic [7:0] hi, input int a);
        exp_q.push_back(hi);
        exp_q.push_back(a[7:0]);
    endtask

    // Valid words of one header+sector block; stops once an address passes the image end.
    task automatic push_sector(input logic [7:0] hi, input int base, input int last, output bit wrapped);
        wrapped = 1'b0;
        for (int c = 0; c < HDRW && !wrapped; c++) begin
            if (base + c > last) wrapped = 1'b1;
            else if (c >= PREW) push_word(hi, base + c);
        end
        for (int c = 0; c < SECW && !wrapped; c++) begin
            if (base + HDRW + c > last) wrapped = 1'b1;
            else if (c >= PREW && !(c >= 8 && c <= 11)) push_word(hi, base + HDRW + c);
        end
    endtask

    task automatic push_pass(input logic [7:0] hi, input int last);
        bit done;
        int base;
        base = 0;
        done = 1'b0;
        while (!done) begin
            push_sector(hi, base, last, done);
            base += S;
        end
    endtask

    task automatic upload(input logic [2:0] drv, input logic [7:0] hi, input int last);
        download = 1'b1;
        dl_drive = drv;
        for (int w = 0; w <= last; w++) begin
            dl_addr = AW'(w);
            dl_wr = 1'b1;
            mem[{drv, AW'(w)}] = {hi, w[7:0]};
            @(negedge clk);
        end
        dl_wr = 1'b0;
        download = 1'b0;
    endtask

    task automatic wait_size(input int target, input string tag);
        int n;
        n = 0;
        while (exp_q.size() > target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(exp_q.size() <= target), 32'd1);
    endtask

    initial begin
        int total;
        int n;
        bit dummy;
        checks = 0;
        errors = 0;
        for (int i = 0; i < (1 << (AW + 3)); i++) mem[i] = 16'h0000;
        reset = 1'b1; sel = '0; download = 1'b0; dl_wr = 1'b0;
        dl_drive = 3'd0; dl_addr = '0; exp_drive = 3'd0;
`ifdef MDV_REVERSE_EN
        reverse = 1'b0;
`endif
        repeat (4) @(negedge clk);
        chk("rst_gap", 32'(gap), 32'd1);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("tx_empty", 32'(tx_empty), 32'd0);
        reset = 1'b0;
        repeat (300) begin
            @(negedge clk);
            chk("idle_no_sel", 32'({gap, rx_ready, dout}), 32'h200);
        end

        // Drive 0: two full passes including the wrap after the last word.
        upload(3'd0, 8'hA5, 40);
        push_pass(8'hA5, 40);
        push_pass(8'hA5, 40);
        sel = 2'b01;
        @(posedge clk); #1;
        chk("sel_on_gap", 32'(gap), 32'd1);
        chk("sel_on_addr", 32'(mem_addr), 32'd0);
        upload(3'd1, 8'h3C, 30);
        repeat (2 * WCLK) @(negedge clk);
        chk("gap_held_2w", 32'(gap), 32'd1);
        wait_size(0, "drive0_two_passes");
        exp_q.delete();

        // Upload on the active drive holds the engine at restart.
        download = 1'b1; dl_drive = 3'd0;
        repeat (10 * WCLK) @(negedge clk);
        chk("hold_gap", 32'(gap), 32'd1);
        chk("hold_addr", 32'(mem_addr), 32'd0);
        download = 1'b0;
        push_pass(8'hA5, 40);
        total = exp_q.size();
        wait_size(total - 12, "drive0_partial");

        // Mid-sector switch to drive 1.
        sel = 2'b10;
        exp_drive = 3'd1;
        exp_q.delete();
        push_pass(8'h3C, 30);
        @(posedge clk); #1;
        chk("switch_gap", 32'(gap), 32'd1);
        chk("switch_addr", 32'(mem_addr), 32'(1 << AW));
        n = 0;
        while (gap === 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("switch_gap_len", 32'(n >= (GAPW - 1) * WCLK && n <= (GAPW + 1) * WCLK), 32'd1);
        wait_size(0, "drive1_pass");
        exp_q.delete();
        sel = 2'b00;

        // Writes to non-existent drives must not alter any end address.
        download = 1'b1; dl_wr = 1'b1; dl_addr = AW'(10);
        dl_drive = 3'd4;
        @(negedge clk);
        dl_drive = 3'd5;
        @(negedge clk);
        dl_wr = 1'b0; download = 1'b0;
        exp_drive = 3'd0;
        push_pass(8'hA5, 40);
        sel = 2'b11;
        wait_size(0, "sel11_drive0_pass");
        exp_q.delete();
        sel = 2'b00;

`ifdef MDV_REVERSE_EN
        upload(3'd0, 8'h5A, 3 * S - 1);
        push_sector(8'h5A, 0, 3 * S - 1, dummy);
        push_sector(8'h5A, 2 * S, 3 * S - 1, dummy);
        push_sector(8'h5A, S, 3 * S - 1, dummy);
        reverse = 1'b1;
        sel = 2'b01;
        wait_size(0, "reverse_order");
        exp_q.delete();
        sel = 2'b00;
        reverse = 1'b0;
        upload(3'd0, 8'hA5, 40);
`endif

        // Reset mid-replay discards end addresses.
        push_pass(8'hA5, 40);
        total = exp_q.size();
        sel = 2'b01;
        wait_size(total - 6, "pre_reset_stream");
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        chk("midrst_gap", 32'(gap), 32'd1);
        chk("midrst_rx_ready", 32'(rx_ready), 32'd0);
        chk("midrst_dout", 32'(dout), 32'd0);
        chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) begin
            repeat (WCLK) @(negedge clk);
            chk("post_reset_gap", 32'(gap), 32'd1);
        end
        sel = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdv_multi.md
Name: mdv_multi

Overview:
- Parametrised multi-drive microdrive replay engine for the QL core.
- Holds the end-address registers for DRIVES cartridge images stored in one shared external word RAM.
- Replays the image of the currently selected drive as a continuous 200 kbit/s byte stream, with header/sector gap timing.
- Generalises the single-drive replay: configurable drive count, image depth, bit rate and framing lengths; select-change restart; optional descending-sector replay.

Parameters:
- DRIVES, 2, number of microdrive units (1..8).
- AW, 17, word-address width per image; per-drive depth is 2^AW words.
- CLK_DIV, 13, ce pulses per bit (2.625 MHz ce / 200 kHz).
- GAP_WORDS, 35, word times per gap.
- HDR_WORDS, 14, words per header block.
- SEC_WORDS, 329, words per sector block.
- PRE_WORDS, 6, leading preamble words of each block masked from rx_ready.

Ports:
- clk  in  1  system clock (21 MHz).
- reset  in  1  synchronous, active-high.
- ce  in  1  clock enable for bit timing.
- sel  in  DRIVES  one-hot motor/select; lowest set bit wins.
- gap  out  1  gap/no-cartridge flag to the IPC/ZX8302.
- tx_empty  out  1  constant 0.
- rx_ready  out  1  byte-available strobe.
- dout  out  8  current byte.
- download  in  1  image upload active.
- dl_drive  in  3  target drive of the upload.
- dl_addr  in  AW  upload word address.
- dl_wr  in  1  upload write strobe (RAM write is external).
- mem_addr  out  3+AW  read address {drive, word}.
- mem_q  in  16  RAM data; registered, 1-cycle latency.

Behaviour:
- Reset values: gap=1, rx_ready=0, dout=0, all end[]=0, word address 0, state GAP_HDR, bit_cnt=0, div=0, data_valid=0, data=0.
- Upload: dl_wr with dl_drive<DRIVES sets end[dl_drive]=dl_addr. dl_drive>=DRIVES is ignored.
- Upload restart: while download is high and dl_drive equals the active drive, the engine holds at restart: address 0, state GAP_HDR, gap count 0.
- Active drive: the lowest set bit of sel.
- present = (sel != 0) && (end[active] != 0).
- gap = !present || state is GAP_HDR or GAP_SEC.
- Select change: any change of the active index, or sel 0→nonzero, restarts the engine on the next clk.
- Bit tick: on ce, div counts 0..CLK_DIV-1 and wraps; a tick is ce with div==0. bit_cnt (4 bits) increments on each tick.
- Word tick: a bit tick with bit_cnt==15. On a word tick:
  - data ← mem_q.
  - data_valid ← data state && cnt>=PRE_WORDS && !(SEC state && cnt in 8..11).
  - cnt increments.
- dout = bit_cnt[3] ? data[7:0] : data[15:8].
- rx_ready = present && data_valid && bit_cnt[2:0]==2. It is a one-bit-time pulse per byte.
- FSM, evaluated on word ticks:
  - GAP_HDR: at cnt==GAP_WORDS-1 → HDR, cnt=0.
  - HDR: address+1 each word; at cnt==HDR_WORDS-1 → GAP_SEC, cnt=0.
  - GAP_SEC: at cnt==GAP_WORDS-1 → SEC, cnt=0.
  - SEC: address+1 each word; at cnt==SEC_WORDS-1 → GAP_HDR, cnt=0.
- Wrap: if address > end[active] on a word tick, restart instead of advancing. Restart takes priority over the FSM.
- Simultaneous events: restart > wrap > FSM advance.
- mem_addr = {active index, word address}. It is stable for ≥15 bit times before use, so read latency is hidden.
- Reset mid-replay: the next clk enters the reset state. end[] is lost and images must be re-uploaded.

Optional Feature:
- Macro: MDV_REVERSE_EN.
- Defined: adds input reverse.
  - Sector size S = HDR_WORDS + SEC_WORDS.
  - When reverse=1 and SEC completes, address jumps backward by 2·S−1 instead of incrementing.
  - If the completed sector ended at address S−1, address jumps instead to end[active]−S+1. Ascending images thus replay in descending sector order.
- Undefined: no reverse port; always ascending.

Test Plan:
- Reset, sel=0 → gap=1, rx_ready never asserts, dout=0 for 10k cycles.
- Upload drive0 words 0..999 with pattern A5xx, sel=01 → gap high for 35 word times; then 14 header words, with rx_ready only from word 6. First valid dout=0xA5.
- Continue drive0 replay → SEC masks words 8..11; gap after 329 words; addresses wrap to 0 after word 999.
- Upload drive1 (end=500) with a distinct pattern, switch sel 01→10 mid-sector → gap=1 on the next clk. mem_addr[AW+2:AW]=1 and word=0; the drive1 pattern appears after 35 word times.
- sel=11 → drive0 streams; dl_drive=5 write with DRIVES=2 → end[] unchanged.
- MDV_REVERSE_EN, reverse=1, 3-sector image (end=1028) → sector order 0, 2, 1, 0 (start addresses 0, 686, 343, 0).
